// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: AXI4-Stream UART transmitter with a transmit FIFO,
// runtime framing (1..DATA_WIDTH data bits, parity, 1/2 stop bits) and
// break generation. One bit period is 8*max(prescale,1) clocks.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic [15:0]                   prescale,
    input  logic [$clog2(DATA_WIDTH):0]   data_bits,
    input  logic [2:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          tx_break
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned NW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_MAB
    } state_e;

    // ---------------- FIFO ----------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  tready_q;
    logic                  push, pop;

    assign push    = s_axis_tvalid && tready_q;
    assign level_d = level_q + LW'(push) - LW'(pop);

    // Storage array write on accepted beats
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q  <= level_d;
            tready_q <= (level_d < LW'(FIFO_DEPTH));
        end
    end

    // ---------------- Serializer ----------------
    state_e                state_q, state_d;
    logic [18:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [NW-1:0]         bitcnt_q, bitcnt_d;
    logic [NW-1:0]         nbits_q, nbits_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_sec_q, stop_sec_d;
    logic                  txd_q, txd_d;

    logic [15:0]           pre_eff;
    logic [18:0]           bit_tm1;
    logic [NW-1:0]         n_eff;
    logic [DATA_WIDTH-1:0] head, mask, ones, shifted;
    logic                  head_xor, tick;

    assign ones     = '1;
    assign pre_eff  = (prescale == '0) ? 16'd1 : prescale;
    assign bit_tm1  = {pre_eff - 16'd1, 3'b111};
    assign n_eff    = ((data_bits == '0) || (data_bits > NW'(DATA_WIDTH)))
                      ? NW'(DATA_WIDTH) : data_bits;
    assign head     = mem_q[rd_ptr_q];
    assign mask     = ~(ones << n_eff);
    assign head_xor = ^(head & mask);
    assign tick     = (cnt_q == '0);
    assign shifted  = shreg_q >> 1;

    // Next-state, bit timer and next txd level; frame setup on pop
    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? cnt_q : cnt_q - 19'd1;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        txd_d      = txd_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tx_break) begin
                    state_d = S_BREAK;
                    txd_d   = 1'b0;
                end else if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    cnt_d   = bit_tm1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                    txd_d    = shreg_q[0];
                    cnt_d    = bit_tm1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d = bit_tm1;
                    if (bitcnt_q == nbits_q - NW'(1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            txd_d      = 1'b1;
                            stop_sec_d = 1'b0;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + NW'(1);
                        shreg_d  = shifted;
                        txd_d    = shifted[0];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    txd_d      = 1'b1;
                    stop_sec_d = 1'b0;
                    cnt_d      = bit_tm1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                        cnt_d      = bit_tm1;
                    end else if ((level_q != '0) && !tx_break) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        txd_d   = 1'b0;
                        cnt_d   = bit_tm1;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                txd_d = 1'b0;
                if (!tx_break) begin
                    state_d = S_MAB;
                    txd_d   = 1'b1;
                    cnt_d   = bit_tm1;
                end
            end
            S_MAB: begin
                if (tick) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Word and framing are captured together so mid-frame input
        // changes cannot affect the frame in flight.
        if (pop) begin
            shreg_d   = head;
            nbits_d   = n_eff;
            stop2_d   = stop_bits;
            par_en_d  = (parity_mode >= 3'd1) && (parity_mode <= 3'd4);
            case (parity_mode)
                3'd1:    par_bit_d = head_xor;
                3'd2:    par_bit_d = ~head_xor;
                3'd3:    par_bit_d = 1'b1;
                default: par_bit_d = 1'b0;
            endcase
        end
    end

    // Serializer state registers; txd is forced high asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            txd_q      <= txd_d;
        end
    end

    assign txd           = txd_q;
    assign s_axis_tready = tready_q;
    assign fifo_level    = level_q;
    assign busy          = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (DATA_WIDTH=8, FIFO_DEPTH=4).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_level;
    logic [15:0] prescale = 16'd1;
    logic [3:0] data_bits = 4'd8;
    logic [2:0] parity_mode = 3'd0;
    logic       stop_bits = 1'b0;
    logic       tx_break = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic       cap_txd  [0:1023];
    logic       cap_busy [0:1023];
    logic       cap_rdy  [0:1023];
    logic [2:0] cap_lvl  [0:1023];
    logic       exp_bits [0:15];

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .txd(txd), .busy(busy),
        .fifo_level(fifo_level), .prescale(prescale), .data_bits(data_bits),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .tx_break(tx_break)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sample n consecutive negedges, the first being the current instant.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap_txd[i]  = txd;
            cap_busy[i] = busy;
            cap_rdy[i]  = s_axis_tready;
            cap_lvl[i]  = fifo_level;
        end
    endtask

    task automatic push_word(input logic [7:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (s_axis_tready === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            s_axis_tdata  = w;
            s_axis_tvalid = 1'b1;
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic wait_txd_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (txd === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic set_cfg(input logic [15:0] p, input logic [3:0] nb,
                           input logic [2:0] pm, input logic sb);
        prescale = p; data_bits = nb; parity_mode = pm; stop_bits = sb;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL rst_txd: got %b expected 1", txd); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b expected 0", s_axis_tready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready_before_edge: got %b expected 0", s_axis_tready); end
        @(negedge clk);
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready_after_edge: got %b expected 1", s_axis_tready); end
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL rst_idle_txd: got %b expected 1", txd); end
    endtask

    task automatic test_8n1;
        bit ok;
        bit bad;
        set_cfg(16'd1, 4'd8, 3'd0, 1'b0);
        {exp_bits[0], exp_bits[1], exp_bits[2], exp_bits[3], exp_bits[4],
         exp_bits[5], exp_bits[6], exp_bits[7], exp_bits[8], exp_bits[9]} = 10'b0101010101;
        push_word(8'h55, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL 8n1_push: got timeout expected accept"); end
        @(negedge clk);
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL 8n1_txd_at_push: got %b expected 1", txd); end
        n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL 8n1_level_at_push: got %0d expected 1", fifo_level); end
        @(negedge clk);
        n_cmp++; if (txd !== 1'b0) begin n_err++; $display("FAIL 8n1_first_word_latency: got %b expected 0", txd); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL 8n1_level_after_pop: got %0d expected 0", fifo_level); end
        capture(81);
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int t = 0; t < 8; t++) if (cap_txd[b*8+t] !== exp_bits[b]) bad = 1'b1;
            n_cmp++; if (bad) begin n_err++; $display("FAIL 8n1_bit%0d: got %b expected %b", b, cap_txd[b*8+3], exp_bits[b]); end
        end
        n_cmp++; if (cap_busy[79] !== 1'b1) begin n_err++; $display("FAIL 8n1_busy_79: got %b expected 1", cap_busy[79]); end
        n_cmp++; if (cap_busy[80] !== 1'b0) begin n_err++; $display("FAIL 8n1_busy_80: got %b expected 0", cap_busy[80]); end
        n_cmp++; if (cap_txd[80] !== 1'b1) begin n_err++; $display("FAIL 8n1_idle_after: got %b expected 1", cap_txd[80]); end
    endtask

    task automatic test_7x2(input logic [2:0] pm, input logic par);
        bit ok;
        bit bad;
        set_cfg(16'd2, 4'd7, pm, 1'b1);
        {exp_bits[0], exp_bits[1], exp_bits[2], exp_bits[3], exp_bits[4], exp_bits[5],
         exp_bits[6], exp_bits[7], exp_bits[8], exp_bits[9], exp_bits[10]} = {9'b010000010, par, 1'b1};
        exp_bits[10] = 1'b1;
        exp_bits[9]  = 1'b1;
        exp_bits[8]  = par;
        push_word(8'h41, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL 7x2_push_mode%0d: got timeout expected accept", pm); end
        wait_txd_low(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL 7x2_start_mode%0d: got timeout expected start bit", pm); end
        capture(177);
        for (int b = 0; b < 11; b++) begin
            bad = 1'b0;
            for (int t = 0; t < 16; t++) if (cap_txd[b*16+t] !== exp_bits[b]) bad = 1'b1;
            n_cmp++; if (bad) begin n_err++; $display("FAIL 7x2_mode%0d_bit%0d: got %b expected %b", pm, b, cap_txd[b*16+7], exp_bits[b]); end
        end
        n_cmp++; if (cap_busy[175] !== 1'b1 || cap_busy[176] !== 1'b0) begin
            n_err++; $display("FAIL 7x2_mode%0d_length: got busy %b%b expected 10", pm, cap_busy[175], cap_busy[176]);
        end
    endtask

    task automatic test_edge_cfg;
        bit ok;
        bit bad;
        set_cfg(16'd0, 4'd0, 3'd6, 1'b0);
        {exp_bits[0], exp_bits[1], exp_bits[2], exp_bits[3], exp_bits[4],
         exp_bits[5], exp_bits[6], exp_bits[7], exp_bits[8], exp_bits[9]} = 10'b0110001011;
        push_word(8'hA3, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL edge_push: got timeout expected accept"); end
        wait_txd_low(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL edge_start: got timeout expected start bit"); end
        capture(81);
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int t = 0; t < 8; t++) if (cap_txd[b*8+t] !== exp_bits[b]) bad = 1'b1;
            n_cmp++; if (bad) begin n_err++; $display("FAIL edge_bit%0d: got %b expected %b", b, cap_txd[b*8+3], exp_bits[b]); end
        end
        n_cmp++; if (cap_busy[79] !== 1'b1 || cap_busy[80] !== 1'b0) begin
            n_err++; $display("FAIL edge_length: got busy %b%b expected 10", cap_busy[79], cap_busy[80]);
        end
    endtask

    task automatic test_back_to_back;
        int idx;
        int first_drop;
        int s0;
        logic [7:0] got;
        logic       st, sp;
        set_cfg(16'd1, 4'd8, 3'd0, 1'b0);
        idx = 0;
        first_drop = -1;
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            cap_txd[c]  = txd;
            cap_busy[c] = busy;
            cap_rdy[c]  = s_axis_tready;
            s_axis_tvalid = (idx < 10);
            s_axis_tdata  = 8'h30 + 8'(idx);
            if (s_axis_tvalid && !s_axis_tready && first_drop < 0) first_drop = idx;
            if (s_axis_tvalid && s_axis_tready) idx++;
        end
        s_axis_tvalid = 1'b0;
        n_cmp++; if (first_drop !== 5) begin n_err++; $display("FAIL b2b_accept_before_full: got %0d expected 5", first_drop); end
        n_cmp++; if (idx !== 10) begin n_err++; $display("FAIL b2b_accepted_total: got %0d expected 10", idx); end
        s0 = -1;
        for (int c = 1; c < 100 && s0 < 0; c++) if (cap_txd[c-1] === 1'b1 && cap_txd[c] === 1'b0) s0 = c;
        n_cmp++; if (s0 < 0) begin n_err++; $display("FAIL b2b_first_start: got none expected start bit"); end
        if (s0 >= 0) begin
            for (int j = 0; j < 10; j++) begin
                got = '0;
                for (int b = 0; b < 8; b++) got[b] = cap_txd[s0 + 80*j + 8*(b+1) + 4];
                st = cap_txd[s0 + 80*j + 4];
                sp = cap_txd[s0 + 80*j + 76];
                n_cmp++; if (got !== 8'h30 + 8'(j) || st !== 1'b0 || sp !== 1'b1) begin
                    n_err++; $display("FAIL b2b_frame%0d: got data %h start %b stop %b expected data %h start 0 stop 1", j, got, st, sp, 8'h30 + 8'(j));
                end
            end
            for (int j = 1; j < 10; j++) begin
                n_cmp++; if (cap_txd[s0 + 80*j - 1] !== 1'b1 || cap_txd[s0 + 80*j] !== 1'b0) begin
                    n_err++; $display("FAIL b2b_spacing%0d: got %b%b expected 10", j, cap_txd[s0 + 80*j - 1], cap_txd[s0 + 80*j]);
                end
            end
            for (int j = 1; j < 6; j++) begin
                n_cmp++; if (cap_rdy[s0 + 80*j - 1] !== 1'b0 || cap_rdy[s0 + 80*j] !== 1'b1 || cap_rdy[s0 + 80*j + 1] !== 1'b0) begin
                    n_err++; $display("FAIL b2b_tready_pop%0d: got %b%b%b expected 010", j,
                                      cap_rdy[s0 + 80*j - 1], cap_rdy[s0 + 80*j], cap_rdy[s0 + 80*j + 1]);
                end
            end
            n_cmp++; if (cap_txd[s0 + 800] !== 1'b1 || cap_busy[s0 + 800] !== 1'b0) begin
                n_err++; $display("FAIL b2b_end_idle: got txd %b busy %b expected txd 1 busy 0", cap_txd[s0 + 800], cap_busy[s0 + 800]);
            end
        end
    endtask

    task automatic test_break;
        bit ok;
        bit bad_txd, bad_lvl, bad;
        set_cfg(16'd1, 4'd8, 3'd0, 1'b0);
        {exp_bits[0], exp_bits[1], exp_bits[2], exp_bits[3], exp_bits[4],
         exp_bits[5], exp_bits[6], exp_bits[7], exp_bits[8], exp_bits[9]} = 10'b0101001011;
        @(negedge clk);
        tx_break = 1'b1;
        push_word(8'hA5, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL brk_push: got timeout expected accept"); end
        bad_txd = 1'b0;
        bad_lvl = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b0 || busy !== 1'b1) bad_txd = 1'b1;
            if (fifo_level !== 3'd1) bad_lvl = 1'b1;
        end
        n_cmp++; if (bad_txd) begin n_err++; $display("FAIL brk_hold_low: got txd %b busy %b expected txd 0 busy 1", txd, busy); end
        n_cmp++; if (bad_lvl) begin n_err++; $display("FAIL brk_level: got %0d expected 1", fifo_level); end
        tx_break = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_err++; $display("FAIL brk_mab: got %b expected 1 for 8 clocks", txd); end
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(negedge clk);
            if (txd === 1'b0) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL brk_frame_start: got timeout expected start bit"); end
        capture(81);
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int t = 0; t < 8; t++) if (cap_txd[b*8+t] !== exp_bits[b]) bad = 1'b1;
            n_cmp++; if (bad) begin n_err++; $display("FAIL brk_bit%0d: got %b expected %b", b, cap_txd[b*8+3], exp_bits[b]); end
        end
        n_cmp++; if (cap_lvl[80] !== 3'd0 || cap_busy[80] !== 1'b0) begin
            n_err++; $display("FAIL brk_end: got level %0d busy %b expected level 0 busy 0", cap_lvl[80], cap_busy[80]);
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        bit bad;
        time t0;
        set_cfg(16'd1, 4'd8, 3'd0, 1'b0);
        push_word(8'h11, ok);
        wait_txd_low(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rmf_start: got timeout expected start bit"); end
        t0 = $time;
        push_word(8'h22, ok);
        push_word(8'h33, ok);
        while ($time < t0 + 340) @(negedge clk);
        n_cmp++; if (fifo_level !== 3'd2 || txd !== 1'b0) begin
            n_err++; $display("FAIL rmf_before: got level %0d txd %b expected level 2 txd 0", fifo_level, txd);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL rmf_async_txd: got %b expected 1", txd); end
        n_cmp++; if (fifo_level !== 3'd0 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            n_err++; $display("FAIL rmf_async_state: got level %0d busy %b tready %b expected 0 0 0", fifo_level, busy, s_axis_tready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL rmf_tready_release: got %b expected 1", s_axis_tready); end
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_err++; $display("FAIL rmf_stays_idle: got txd %b busy %b level %0d expected 1 0 0", txd, busy, fifo_level); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7x2(3'd1, 1'b0);
        test_7x2(3'd2, 1'b1);
        test_edge_cfg();
        test_back_to_back();
        test_break();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

AXI4-Stream UART transmitter with an internal transmit FIFO and runtime-selectable framing: 1..DATA_WIDTH data bits, none/even/odd/mark/space parity, 1 or 2 stop bits, plus break generation. It sits between a stream source and the `txd` pin. The FIFO decouples bursty producers from the serial line and allows back-to-back frames with no idle gap. Each bit period is 8×prescale clocks, matching the existing UART blocks.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame; this is also the width of `s_axis_tdata`. Must be ≥1.
- FIFO_DEPTH, 4: number of FIFO entries. Must be a power of two and ≥2.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  word to send; only the low `data_bits` bits are transmitted
- s_axis_tvalid  in  1  source has a word
- s_axis_tready  out  1  FIFO can accept a word (registered)
- txd  out  1  serial output; idle level is high
- busy  out  1  serializer not IDLE, or FIFO not empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of entries held in the FIFO
- prescale  in  16  bit period T = 8×max(prescale,1) clocks
- data_bits  in  $clog2(DATA_WIDTH)+1  data bits per frame; a value of 0 or >DATA_WIDTH means DATA_WIDTH
- parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; values 5–7 mean none
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits
- tx_break  in  1  request to hold the line low (break)

## Operation
- **Reset (rst_n low, asynchronous):**
  - txd=1, s_axis_tready=0, busy=0, fifo_level=0.
  - FIFO is emptied and the state goes to IDLE.
  - s_axis_tready rises on the first clk edge after release.
- **FIFO push and tready:**
  - A push occurs on any edge where tvalid && tready.
  - tready is a register: tready <= (next level < FIFO_DEPTH).
  - At full, a pop does not raise tready in the same cycle. tready rises one edge after the pop.
- **FIFO pop:** in IDLE with level>0 and tx_break=0, the head word is popped and latched. data_bits, parity_mode and stop_bits are latched on that same edge. Mid-frame changes to configuration inputs have no effect on the current frame.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK, MAB (mark-after-break).
  - IDLE: txd=1.
  - START: txd=0 for T.
  - DATA: LSB first, one bit per T, n bits.
  - PARITY: present only if the latched mode is not none. Lasts T.
  - STOP: txd=1 for T, or 2T when two stop bits are selected.
  - After the last stop period:
    - FIFO non-empty and tx_break=0: pop and enter START on the same edge. There is zero idle between frames.
    - Otherwise: enter IDLE.
- **Parity bit:**
  - even: XOR of the n transmitted bits.
  - odd: inverse of that XOR.
  - mark: 1.
  - space: 0.
- **Break:**
  - IDLE with tx_break=1 goes to BREAK, with txd=0. tx_break has priority over a pending FIFO pop.
  - BREAK holds while tx_break=1. On deassertion it goes to MAB: txd=1 for T, then IDLE.
  - tx_break asserted mid-frame is ignored until the frame ends.
  - Pushes continue during BREAK and MAB.
- **Bit timer:**
  - 19-bit down-counter loaded with T−1 at each bit start.
  - The bit advances when the counter is 0.
  - prescale=0 is treated as 1.
- **busy** = (state≠IDLE) || (fifo_level≠0).

## Timing
- **First-word latency:** a word accepted at edge k into an empty FIFO with an IDLE serializer lands in the FIFO at k. It is popped at k+1, and txd falls at k+1.
- **Frame length:** (1 + n + p + s)×T clocks.
  - p = 0 or 1 (parity present or not).
  - s = 1 or 2 (stop bits).
- **Back-to-back frames:** the next start-bit edge is exactly one frame length after the previous start-bit edge.
- **Outputs are glitch-free:** txd, s_axis_tready and fifo_level are registered. busy is a combinational function of registered state only.
- **Simultaneous push and pop:** fifo_level is unchanged. Pointers wrap modulo FIFO_DEPTH.
- **Reset mid-frame:** txd returns high immediately, with no clock required. No partial frame resumes after reset release.

## Test plan
- **8N1 frame:** prescale=1, data_bits=8, parity=0, stop=0; push 0x55 → txd = 0,1,0,1,0,1,0,1,0,1, each level for 8 clks; total 80 clks; busy falls at clk 80.
- **7E2 and 7O2 frames:** prescale=2, data_bits=7; push 0x41 →
  - even: txd = 0, 1000001 (LSB first), parity 0, 1,1; each bit 16 clks; total 176 clks.
  - odd: same frame with parity bit 1.
- **Continuous push:** FIFO_DEPTH=4, 8N1, prescale=1; tvalid held 1 with 10 words →
  - 5 words accepted before tready first drops (4 in FIFO, 1 in flight).
  - tready re-rises 1 clk after each pop.
  - Start bits spaced exactly 80 clks apart, with no idle high between frames.
- **Break:** FIFO holds 0xA5; tx_break=1 while IDLE for 100 clks → txd=0 for those 100 clks; after deassertion, txd=1 for T (MAB); then the 0xA5 frame is sent; fifo_level stays 1 throughout the break.
- **Reset mid-frame:** rst_n low during data bit 3 with 2 words queued → txd=1 asynchronously; fifo_level=0, busy=0, tready=0; after release, tready=1 on the next edge and the line stays idle.
- **Edge configuration:** prescale=0 → T=8; data_bits=0 → 8 data bits sent; parity_mode=6 → no parity bit.
